// File: rtl/scu_isa_pkg.sv
// SCU-ISA shared definitions: opcodes, control FSM states, datapath select
// codes and fault causes, plus an opcode legality check used at decode.
package scu_isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_NEG  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_JM   = 4'hA;
  localparam logic [3:0] OP_BRN  = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_SVPC = 4'hF;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_RS  = 2'd1;
  localparam logic [1:0] PC_SRC_MEM = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_PCRL = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_NEG = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
      OP_J, OP_BRZ, OP_JM, OP_BRN, OP_LD, OP_SVPC: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ack.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : zero the count (asserted on every FSM state change)
//   en_i       : a waiting cycle with no ack
//   expired_o  : this waiting cycle brings the count to MEM_TIMEOUT
// MEM_TIMEOUT = 0 disables expiry and freezes the counter.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (MEM_TIMEOUT != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == LAST_C);

endmodule

// File: rtl/scu_multicycle_ctrl.sv
// SCU-ISA multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB sequencing
// with instruction/data memory handshakes, memory timeout and illegal-opcode
// faults.
//   clk, rst_n        : clock, async active-low reset
//   run               : start execution (sampled in IDLE only)
//   instr_op          : IR[31:28], valid from DECODE onward
//   mem_ack           : completion pulse from the requested memory
//   flag_z, flag_n    : latched ALU flags, used by BRZ/BRN
//   imem_req, ir_we   : instruction fetch request / IR load
//   dmem_req, dmem_we : data memory request / write qualifier
//   pc_we, pc_src     : PC update and source select
//   reg_we, wb_sel    : register write and writeback source select
//   alu_op, alu_b_sel : ALU function and operand-B select
//   flags_we          : latch Z/N from ALU result
//   retire            : one pulse per completed instruction
//   fault, fault_cause: sticky fault and its cause
module scu_multicycle_ctrl
  import scu_isa_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] instr_op,
  input  logic       mem_ack,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_op,
  output logic       alu_b_sel,
  output logic       flags_we,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_cause
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [1:0] cause_q, cause_d;
  logic       timer_clr, timer_en, timer_exp;

  // Any state change restarts the wait count, so FETCH reached straight from
  // MEM (ST/JM) still starts from zero.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_exp)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_INC;
    reg_we    = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    flags_we  = 1'b0;
    retire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_exp) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_DECODE: begin
        op_d = instr_op;
        if (op_legal(instr_op)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FAULT;
          cause_d = CAUSE_ILLEGAL;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_NOP: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          OP_ADD: begin
            flags_we = 1'b1;
            state_d  = ST_WB;
          end
          OP_INC: begin
            alu_b_sel = 1'b1;
            flags_we  = 1'b1;
            state_d   = ST_WB;
          end
          OP_NEG: begin
            alu_op   = ALU_NEG;
            flags_we = 1'b1;
            state_d  = ST_WB;
          end
          OP_SUB: begin
            alu_op   = ALU_SUB;
            flags_we = 1'b1;
            state_d  = ST_WB;
          end
          OP_SVPC: state_d = ST_WB;
          OP_LD, OP_ST, OP_JM: state_d = ST_MEM;
          OP_J: begin
            pc_we   = 1'b1;
            pc_src  = PC_SRC_RS;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          OP_BRZ: begin
            pc_we   = 1'b1;
            pc_src  = flag_z ? PC_SRC_RS : PC_SRC_INC;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          OP_BRN: begin
            pc_we   = 1'b1;
            pc_src  = flag_n ? PC_SRC_RS : PC_SRC_INC;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            state_d = ST_FAULT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_ST);
        if (mem_ack) begin
          if (op_q == OP_LD) begin
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            pc_src  = (op_q == OP_JM) ? PC_SRC_MEM : PC_SRC_INC;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (timer_exp) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (op_q == OP_SVPC) ? WB_SEL_PCRL :
                  (op_q == OP_LD)   ? WB_SEL_MEM  : WB_SEL_ALU;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
    end
  end

  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: doc/scu_multicycle_ctrl.md
Name: scu_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the SCU-ISA datapath.
- Sequences fetch, decode, execute, memory and writeback for each 32-bit instruction. Opcode is [31:28]; rd/rs/rt are 6-bit fields.
- Steers ALU operand B between the rt register value and the sign-extended 6-bit rt immediate.
- Handshakes with instruction and data memory; faults on memory timeout or illegal opcode.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ack before FAULT; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution; sampled in IDLE only.
- instr_op  in  4  IR[31:28]; valid from DECODE onward.
- mem_ack  in  1  one-cycle completion pulse from whichever memory is requested.
- flag_z  in  1  latched zero flag.
- flag_n  in  1  latched negative flag.
- imem_req  out  1  instruction read request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write qualifier, valid with dmem_req.
- ir_we  out  1  load IR.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+1, 1 = rs value, 2 = memory read data.
- reg_we  out  1  register file write.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC + sext(rt).
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = NEG (0 - rs).
- alu_b_sel  out  1  0 = R[rt], 1 = sext(rt).
- flags_we  out  1  latch Z/N from ALU result.
- retire  out  1  one-cycle pulse per completed instruction.
- fault  out  1  sticky fault indication.
- fault_cause  out  2  01 = memory timeout, 10 = illegal opcode.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset:
  - state = IDLE; op_q = 0; timeout counter = 0; fault = 0; fault_cause = 0.
  - All strobes 0, pc_src = 0, wb_sel = 0, alu_op = 0, alu_b_sel = 0.
- Output decoding:
  - Outputs are decoded combinationally from registered state and op_q only; mem_ack and the flags enter through next-state and the pc_we of single transitions.
  - In IDLE and FAULT every output is 0, except fault and fault_cause.
- IDLE: run = 1 -> FETCH; otherwise hold.
- FETCH:
  - imem_req = 1, held until mem_ack.
  - On mem_ack: ir_we = 1 that cycle -> DECODE.
- DECODE (1 cycle):
  - op_q <= instr_op.
  - Opcodes outside {0,3,4,5,6,7,8,9,A,B,E,F} -> FAULT with cause 10.
  - Otherwise -> EXEC.
- EXEC (1 cycle), per op_q:
  - NOP(0): pc_we, pc_src = 0, retire -> FETCH.
  - ADD(4): alu_op = 0, alu_b_sel = 0, flags_we -> WB.
  - INC(5): alu_op = 0, alu_b_sel = 1, flags_we -> WB.
  - NEG(6): alu_op = 2, flags_we -> WB.
  - SUB(7): alu_op = 1, alu_b_sel = 0, flags_we -> WB.
  - SVPC(F): -> WB with wb_sel = 2.
  - LD(E), ST(3), JM(A): -> MEM.
  - J(8): pc_we, pc_src = 1, retire -> FETCH.
  - BRZ(9): pc_we = 1; pc_src = flag_z ? 1 : 0; retire -> FETCH.
  - BRN(B): pc_we = 1; pc_src = flag_n ? 1 : 0; retire -> FETCH.
- MEM:
  - dmem_req = 1; dmem_we = (op_q == ST). Held until mem_ack.
  - On ack, ST: pc_we, pc_src = 0, retire -> FETCH.
  - On ack, LD: -> WB with wb_sel = 1.
  - On ack, JM: pc_we, pc_src = 2, retire -> FETCH.
- WB (1 cycle):
  - reg_we = 1; wb_sel = 2 for SVPC, 1 for LD, else 0.
  - pc_we = 1, pc_src = 0, retire = 1 -> FETCH.
- Flags: branches see flags written by the most recent ALU op. flags_we never asserts in the same cycle as a branch EXEC.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each waiting cycle.
  - Counter reaching MEM_TIMEOUT with no ack -> FAULT, cause 01.
  - mem_ack arriving in the same cycle as expiry wins; no fault.
- FAULT: sticky; exit only via rst_n.
- mem_ack outside FETCH/MEM is ignored.
- run deasserting mid-instruction has no effect; it is checked only in IDLE, which is re-entered only through reset.
- rst_n asserted mid-MEM: immediate return to IDLE with all requests dropped; the memory side must tolerate an abandoned request.
- Latencies (zero-wait memory, ack in the first request cycle):
  - ALU ops and SVPC: 4 cycles.
  - J, BRZ, BRN, NOP: 3 cycles.
  - ST, JM: 4 cycles.
  - LD: 5 cycles.

Decomposition:
- Package scu_isa_pkg holds:
  - opcode localparams;
  - FSM state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT; 3 bits);
  - pc_src, wb_sel and alu_op codes;
  - fault cause codes.
- Sub-module mem_wait_timer (clear, count enable, expired output), parameterised by MEM_TIMEOUT/CNT_W.

Test Plan:
- Reset, run = 1, INC op (5), ack in the first cycle -> cycle trace FETCH, DECODE, EXEC (alu_b_sel = 1, flags_we), WB (reg_we, pc_we), retire on cycle 4.
- BRZ with flag_z = 1, then flag_z = 0 -> EXEC pc_src = 1, then pc_src = 0; pc_we = 1 both times; no reg_we.
- LD with mem_ack delayed 3 cycles -> dmem_req held high 4 cycles, dmem_we = 0, WB wb_sel = 1, retire 8 cycles after entering FETCH.
- MEM_TIMEOUT = 4, no ack in FETCH -> FAULT after 4 wait cycles, fault_cause = 01, outputs 0 until rst_n.
- Opcode 0x2 -> FAULT cause 10 at DECODE + 1; ack coinciding with timeout expiry -> no fault.
- rst_n pulsed low mid-MEM during ST -> dmem_req drops asynchronously, state IDLE, no retire.
